// File: rtl/blakley_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Blakley modular
// multiplier through a start/done handshake; owns operand latching, bit scan and errors.
module blakley_modexp_ctrl #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned EXP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_n,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_result,
    output logic [7:0]           mul_count
);

    localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StSqReq, StSqWait, StMulReq, StMulWait, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d, mod_q, mod_d, acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     mul_n_q, mul_n_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IdxW-1:0]      idx_q, idx_d, msb;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;

    always_comb begin
        msb = '0;
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (exp_q[i]) msb = IdxW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        mul_n_d  = mul_n_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    mod_d   = modulus;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (mod_q < WIDTH'(2) || base_q >= mod_q) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StDone;
                end else if (exp_q == '0) begin
                    acc_d    = WIDTH'(1);
                    result_d = WIDTH'(1);
                    state_d  = StDone;
                end else begin
                    acc_d = base_q;
                    if (msb == '0) begin
                        result_d = base_q;
                        state_d  = StDone;
                    end else begin
                        idx_d   = msb - IdxW'(1);
                        state_d = StSqReq;
                    end
                end
            end
            StSqReq, StMulReq: begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                state_d = (state_q == StSqReq) ? StSqWait : StMulWait;
            end
            StSqWait, StMulWait: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (state_q == StSqWait && exp_q[idx_q]) begin
                        state_d = StMulReq;
                    end else if (idx_q == '0) begin
                        result_d = mul_result;
                        state_d  = StDone;
                    end else begin
                        idx_d   = idx_q - IdxW'(1);
                        state_d = StSqReq;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Operands are registered on entry to a request state so they are valid with
        // mul_start and stay frozen for the whole wait.
        if (state_d == StSqReq && state_q != StSqReq) begin
            mul_a_d = acc_d;
            mul_b_d = acc_d;
            mul_n_d = mod_q;
        end else if (state_d == StMulReq && state_q != StMulReq) begin
            mul_a_d = acc_d;
            mul_b_d = base_q;
            mul_n_d = mod_q;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= StIdle;
            base_q   <= '0;
            mod_q    <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_n_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_n_q  <= mul_n_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        mul_start = (state_q == StSqReq) || (state_q == StMulReq);
        err       = err_q;
        result    = result_q;
        mul_a     = mul_a_q;
        mul_b     = mul_b_q;
        mul_n     = mul_n_q;
        mul_count = cnt_q;
    end

endmodule

// File: tb/tb_blakley_modexp_ctrl.sv
// Directed bench for blakley_modexp_ctrl: behavioural multiplier with configurable latency,
// expected results queued at stimulus time and checked when done pulses.
module tb_blakley_modexp_ctrl;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base = '0, modulus = '0;
    logic [4:0] exponent = '0;
    logic       busy, done, err, mul_start;
    logic [4:0] result, mul_a, mul_b, mul_n;
    logic       mul_done = 1'b0;
    logic [4:0] mul_result = '0;
    logic [7:0] mul_count;

    int n_assert = 0;
    int n_fail = 0;

    // multiplier model state (written only by the model process)
    int         n_starts = 0;
    int         stab_errs = 0;
    int         overlap_errs = 0;
    int         spur_ack = 0;
    bit         pend = 0;
    bit         orphan = 0;
    int         cnt = 0;
    logic [4:0] cap_a, cap_b, cap_n;

    // model controls (written only by the stimulus process)
    int lat_fixed = 7;
    bit spur_mode = 0;
    int spur_req = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       err;
        logic [4:0] res;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    blakley_modexp_ctrl #(.WIDTH(5), .EXP_WIDTH(5)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .modulus   (modulus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_n     (mul_n),
        .mul_done  (mul_done),
        .mul_result(mul_result),
        .mul_count (mul_count)
    );

    always @(negedge clk) begin
        mul_done = 1'b0;
        if (!reset_l && pend) orphan = 1;
        if (pend) begin
            if (!orphan && (mul_a !== cap_a || mul_b !== cap_b || mul_n !== cap_n))
                stab_errs++;
            cnt--;
            if (cnt == 0) begin
                pend = 0;
                mul_done = 1'b1;
                mul_result = (cap_n == 0) ? 5'd0 : 5'((int'(cap_a) * int'(cap_b)) % int'(cap_n));
            end
        end
        if (spur_req != spur_ack) begin
            spur_ack = spur_req;
            mul_done = 1'b1;
            mul_result = 5'($urandom);
        end
        if (mul_start === 1'b1 && reset_l) begin
            if (pend) overlap_errs++;
            cap_a = mul_a;
            cap_b = mul_b;
            cap_n = mul_n;
            cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(20, 1));
            pend = 1;
            orphan = 0;
            n_starts++;
            // a done in the same cycle as the request must be ignored
            if (spur_mode) begin
                mul_done = 1'b1;
                mul_result = 5'($urandom);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t golden(input int b, input int e, input int m);
        exp_t x;
        int r, top;
        x = '0;
        if (m < 2 || b >= m) begin
            x.err = 1'b1;
        end else if (e == 0) begin
            x.res = 5'd1;
        end else begin
            r = 1;
            for (int i = 0; i < e; i++) r = (r * b) % m;
            top = 0;
            for (int i = 0; i < 5; i++) if ((e >> i) & 1) top = i;
            x.res = 5'(r);
            x.cnt = 8'(top + $countones(5'(e)) - 1);
        end
        return x;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_abn"}, {mul_a, mul_b, mul_n}, 0);
        check({tag, "_mul_count"}, mul_count, 0);
    endtask

    task automatic run_op(input string tag, input int b, input int e, input int m,
                          input int lat_exp, input bit extra);
        exp_t x;
        int cyc, starts0, stab0, ovl0;
        bit busy_bad;
        starts0 = n_starts;
        stab0 = stab_errs;
        ovl0 = overlap_errs;
        sb.push_back(golden(b, e, m));
        base = 5'(b);
        exponent = 5'(e);
        modulus = 5'(m);
        start = 1'b1;
        cyc = 0;
        busy_bad = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1 || cyc > 3000) break;
            if (busy !== 1'b1) busy_bad = 1;
            start = extra && (cyc % 3 == 0);
            if (start) begin
                base = 5'($urandom);
                exponent = 5'($urandom);
                modulus = 5'($urandom);
            end
        end
        start = 1'b0;
        x = sb.pop_front();
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_result"}, result, x.res);
        check({tag, "_err"}, err, x.err);
        check({tag, "_mul_count"}, mul_count, x.cnt);
        check({tag, "_mul_starts"}, n_starts - starts0, x.cnt);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_busy_throughout"}, busy_bad, 0);
        check({tag, "_operands_stable"}, stab_errs - stab0, 0);
        check({tag, "_no_overlap"}, overlap_errs - ovl0, 0);
        if (lat_exp > 0) check({tag, "_latency"}, cyc, lat_exp);
        @(negedge clk);
        check({tag, "_single_done"}, done, 0);
        check({tag, "_result_held"}, result, x.res);
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset_l = 1'b1;
        @(negedge clk);

        lat_fixed = 7;
        run_op("p4e13m29", 4, 13, 29, -1, 0);
        run_op("e0", 7, 0, 11, 2, 0);
        run_op("e1", 9, 1, 31, 2, 0);
        run_op("base_eq_mod", 12, 1, 12, 2, 0);
        run_op("mod1", 0, 3, 1, 2, 0);

        lat_fixed = 0;
        run_op("p3e31m31", 3, 31, 31, -1, 1);

        // abort in SQ_WAIT, then let the orphaned multiplier result arrive
        lat_fixed = 10;
        base = 5'd4;
        exponent = 5'd13;
        modulus = 5'd29;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!pend && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_wait", pend, 1);
        repeat (2) @(negedge clk);
        reset_l = 1'b0;
        @(negedge clk);
        check_idle_zero("in_reset");
        reset_l = 1'b1;
        repeat (15) @(negedge clk);
        check("stray_done_delivered", pend, 0);
        check_idle_zero("after_stray");
        lat_fixed = 3;
        run_op("p2e5m13", 2, 5, 13, -1, 0);

        // spurious done pulses while idle and in request cycles
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_result", result, 6);
        spur_mode = 1;
        run_op("spur_p5e23m27", 5, 23, 27, -1, 0);
        lat_fixed = 0;
        run_op("spur_p11e19m29", 11, 19, 29, -1, 0);
        spur_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
